peak_event_extractor: RTL and testbench

PEAK_EVENT_EXTRACTOR -- requirements
Module: peak_event_extractor

---
 rtl/peak_event_extractor_if.sv | 27 ++
 rtl/peak_event_extractor.sv | 174 +++++++++++++++++
 tb/tb_peak_event_extractor.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/peak_event_extractor_if.sv
// Sample-in / event-record-out bundle for the peak event extractor.
// The master drives samples and the consumer ready; the slave returns records.
interface peak_event_extractor_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 16
);
  logic signed [DATA_WIDTH-1:0] filtered_in;
  logic                         peak_in;
  logic                         valid_in;
  logic                         evt_ready;
  logic                         evt_valid;
  logic signed [DATA_WIDTH-1:0] evt_max;
  logic [IDX_WIDTH-1:0]         evt_index;
  logic [7:0]                   evt_width;
  logic [IDX_WIDTH-1:0]         evt_interval;
  logic                         overflow;

  modport master (
    output filtered_in, peak_in, valid_in, evt_ready,
    input  evt_valid, evt_max, evt_index, evt_width, evt_interval, overflow
  );

  modport slave (
    input  filtered_in, peak_in, valid_in, evt_ready,
    output evt_valid, evt_max, evt_index, evt_width, evt_interval, overflow
  );
endinterface

// File: rtl/peak_event_extractor.sv
// Groups qualified peak samples into events (max, index, width, interval)
// and queues the records in a small FIFO for a ready/valid consumer.
//
// state   | meaning
// IDLE    | waiting for an accepted sample with peak_in=1
// IN_PEAK | accumulating a peak run (length, max, index of max)
// HOLD    | ignoring HOLDOFF accepted samples after a pushed event
module peak_event_extractor #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 16,
  parameter int MIN_WIDTH  = 2,
  parameter int HOLDOFF    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  peak_event_extractor_if.slave  io_bus
);

  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          HOLD_W    = $clog2(HOLDOFF + 2);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF);
  localparam logic [7:0]  MIN_LEN   = 8'(MIN_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_IN_PEAK, S_HOLD} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [IDX_WIDTH-1:0]         r_idx;
  logic [7:0]                   r_run_len;
  logic signed [DATA_WIDTH-1:0] r_max;
  logic [IDX_WIDTH-1:0]         r_max_idx;
  logic [HOLD_W-1:0]            r_hold_cnt;
  logic [IDX_WIDTH-1:0]         r_prev_idx;
  logic                         r_have_prev;
  logic                         r_overflow;

  logic w_start;
  logic w_extend;
  logic w_close;
  logic w_hold_load;
  logic w_hold_dec;

  logic [PTR_W:0]               r_wr_ptr;
  logic [PTR_W:0]               r_rd_ptr;
  logic signed [DATA_WIDTH-1:0] r_mem_max   [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0]         r_mem_idx   [FIFO_DEPTH];
  logic [7:0]                   r_mem_width [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0]         r_mem_int   [FIFO_DEPTH];

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_drop;
  logic [IDX_WIDTH-1:0] w_interval;
  logic [PTR_W-1:0]     w_wr_addr;
  logic [PTR_W-1:0]     w_rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_extend    = 1'b0;
    w_close     = 1'b0;
    w_hold_load = 1'b0;
    w_hold_dec  = 1'b0;
    if (io_bus.valid_in) begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.peak_in) begin
            w_start     = 1'b1;
            w_state_nxt = S_IN_PEAK;
          end
        end
        S_IN_PEAK: begin
          if (io_bus.peak_in) begin
            w_extend = 1'b1;
          end else if (r_run_len >= MIN_LEN) begin
            w_close = 1'b1;
            if (HOLDOFF == 0) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_hold_load = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_HOLD: begin
          // Terminal count: the sample that brings the count to zero is consumed here.
          w_hold_dec = 1'b1;
          if (r_hold_cnt == HOLD_W'(1)) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_run_len  <= '0;
      r_max      <= '0;
      r_max_idx  <= '0;
      r_hold_cnt <= '0;
    end else if (io_bus.valid_in) begin
      r_idx <= r_idx + 1'b1;
      if (w_start) begin
        r_run_len <= 8'd1;
        r_max     <= io_bus.filtered_in;
        r_max_idx <= r_idx;
      end else if (w_extend) begin
        if (r_run_len != 8'hFF) r_run_len <= r_run_len + 8'd1;
        if (io_bus.filtered_in > r_max) begin
          r_max     <= io_bus.filtered_in;
          r_max_idx <= r_idx;
        end
      end
      if (w_hold_load)     r_hold_cnt <= HOLD_INIT;
      else if (w_hold_dec) r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
    end
  end

  assign w_wr_addr  = r_wr_ptr[PTR_W-1:0];
  assign w_rd_addr  = r_rd_ptr[PTR_W-1:0];
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) && (w_wr_addr == w_rd_addr);
  assign w_pop      = !w_empty && io_bus.evt_ready;
  assign w_push_ok  = w_close && (!w_full || w_pop);
  assign w_drop     = w_close && w_full && !w_pop;
  assign w_interval = r_have_prev ? (r_max_idx - r_prev_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_prev_idx  <= '0;
      r_have_prev <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_prev_idx  <= r_max_idx;
        r_have_prev <= 1'b1;
      end
      if (w_pop)  r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Record storage needs no reset: it is only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_max[w_wr_addr]   <= r_max;
      r_mem_idx[w_wr_addr]   <= r_max_idx;
      r_mem_width[w_wr_addr] <= r_run_len;
      r_mem_int[w_wr_addr]   <= w_interval;
    end
  end

  assign io_bus.evt_valid    = !w_empty;
  assign io_bus.evt_max      = w_empty ? '0 : r_mem_max[w_rd_addr];
  assign io_bus.evt_index    = w_empty ? '0 : r_mem_idx[w_rd_addr];
  assign io_bus.evt_width    = w_empty ? '0 : r_mem_width[w_rd_addr];
  assign io_bus.evt_interval = w_empty ? '0 : r_mem_int[w_rd_addr];
  assign io_bus.overflow     = r_overflow;

endmodule

// File: tb/tb_peak_event_extractor.sv
// Directed bench for peak_event_extractor: event capture, holdoff, FIFO
// overflow, width saturation, throttled input and asynchronous reset.
module tb_peak_event_extractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  peak_event_extractor_if #(.DATA_WIDTH(16), .IDX_WIDTH(16)) bus ();

  peak_event_extractor #(
    .DATA_WIDTH(16), .IDX_WIDTH(16), .MIN_WIDTH(2), .HOLDOFF(8), .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int mx, input int idx, input int wd, input int itv);
    chk({tag, ".valid"},    32'(bus.evt_valid),    32'd1);
    chk({tag, ".max"},      32'(bus.evt_max),      32'(mx));
    chk({tag, ".index"},    32'(bus.evt_index),    32'(idx));
    chk({tag, ".width"},    32'(bus.evt_width),    32'(wd));
    chk({tag, ".interval"}, 32'(bus.evt_interval), 32'(itv));
  endtask

  // One accepted sample; returns 1 time unit after the accepting edge.
  task automatic smp(input int v, input logic p);
    bus.filtered_in = 16'(v);
    bus.peak_in     = p;
    bus.valid_in    = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.peak_in  = 1'b0;
  endtask

  // Idle cycles carry junk that must be ignored.
  task automatic idle(input int n);
    bus.valid_in    = 1'b0;
    bus.filtered_in = 16'sd1000;
    bus.peak_in     = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    bus.peak_in = 1'b0;
  endtask

  task automatic do_reset;
    bus.valid_in    = 1'b0;
    bus.peak_in     = 1'b0;
    bus.filtered_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int exp_max [4] = '{2, 12, 22, 32};
  int exp_idx [4] = '{1, 12, 23, 34};
  int exp_int [4] = '{0, 11, 11, 11};

  initial begin
    bus.evt_ready   = 1'b1;
    bus.valid_in    = 1'b0;
    bus.peak_in     = 1'b0;
    bus.filtered_in = '0;

    // Basic event: peaks at 3,4,5 values 10,30,20
    do_reset();
    chk("rst.valid",    32'(bus.evt_valid),    32'd0);
    chk("rst.max",      32'(bus.evt_max),      32'd0);
    chk("rst.index",    32'(bus.evt_index),    32'd0);
    chk("rst.width",    32'(bus.evt_width),    32'd0);
    chk("rst.interval", 32'(bus.evt_interval), 32'd0);
    chk("rst.overflow", 32'(bus.overflow),     32'd0);
    bus.evt_ready = 1'b1;
    smp(0, 0); smp(0, 0); smp(0, 0);
    smp(10, 1); smp(30, 1); smp(20, 1);
    chk("s1.pre_valid", 32'(bus.evt_valid), 32'd0);
    smp(0, 0);
    chk_rec("s1.rec", 30, 4, 3, 0);
    smp(0, 0);
    chk("s1.popped", 32'(bus.evt_valid), 32'd0);
    smp(0, 0); smp(0, 0);

    // Short run discarded, then a two-sample run
    do_reset();
    smp(0, 0); smp(0, 0); smp(0, 0);
    smp(50, 1); smp(0, 0);
    chk("s2.short_none", 32'(bus.evt_valid), 32'd0);
    smp(7, 1); smp(9, 1);
    chk("s2.pre_valid", 32'(bus.evt_valid), 32'd0);
    smp(0, 0);
    chk_rec("s2.rec", 9, 6, 2, 0);

    // Holdoff: event terminates at 5 (tie keeps index 3), peaks 6..13 ignored
    do_reset();
    smp(0, 0); smp(0, 0);
    smp(5, 1); smp(8, 1); smp(8, 1);
    smp(0, 0);
    chk_rec("s3.rec1", 8, 3, 3, 0);
    for (int i = 6; i <= 13; i++) smp(100, 1);
    chk("s3.hold_none", 32'(bus.evt_valid), 32'd0);
    smp(40, 1); smp(60, 1);
    chk("s3.pre_valid", 32'(bus.evt_valid), 32'd0);
    smp(0, 0);
    chk_rec("s3.rec2", 60, 15, 2, 12);

    // FIFO overflow with consumer stalled
    do_reset();
    bus.evt_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      smp(10 * k + 1, 1); smp(10 * k + 2, 1); smp(0, 0);
      for (int h = 0; h < 8; h++) smp(0, 0);
      if (k == 3) chk("s4.ovf_before", 32'(bus.overflow), 32'd0);
    end
    chk("s4.ovf_after", 32'(bus.overflow), 32'd1);
    idle(2);
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_rec($sformatf("s4.drain%0d", i), exp_max[i], exp_idx[i], 2, exp_int[i]);
      idle(1);
    end
    chk("s4.empty",    32'(bus.evt_valid), 32'd0);
    chk("s4.ovf_held", 32'(bus.overflow),  32'd1);
    smp(1, 1); smp(2, 1); smp(0, 0);
    chk_rec("s4.after_drop", 2, 56, 2, 22);

    // 300-sample run with valid_in toggling: width saturates
    do_reset();
    smp(0, 0);
    for (int i = 1; i <= 300; i++) begin
      smp((i == 150) ? 77 : 3, 1);
      idle(1);
    end
    chk("s5.pre_valid", 32'(bus.evt_valid), 32'd0);
    smp(0, 0);
    chk_rec("s5.rec", 77, 150, 255, 0);

    // Async reset mid-run with a record still queued
    do_reset();
    bus.evt_ready = 1'b0;
    smp(0, 0); smp(0, 0); smp(0, 0); smp(0, 0);
    smp(6, 1); smp(9, 1); smp(0, 0);
    chk_rec("s6.rec1", 9, 5, 2, 0);
    for (int h = 0; h < 8; h++) smp(0, 0);
    smp(5, 1); smp(5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6.async_valid",    32'(bus.evt_valid),    32'd0);
    chk("s6.async_max",      32'(bus.evt_max),      32'd0);
    chk("s6.async_index",    32'(bus.evt_index),    32'd0);
    chk("s6.async_width",    32'(bus.evt_width),    32'd0);
    chk("s6.async_interval", 32'(bus.evt_interval), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.evt_ready = 1'b1;
    smp(0, 0); smp(0, 0);
    chk("s6.no_record", 32'(bus.evt_valid), 32'd0);
    smp(4, 1); smp(7, 1); smp(0, 0);
    chk_rec("s6.rec2", 7, 3, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
